// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default datapath widths, player state encoding
// and the project sample-ROM clip table.
package audio_pkg;

    localparam int DEF_ADDR_W   = 18;
    localparam int DEF_SAMPLE_W = 6;
    localparam int DEF_OUT_W    = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } play_state_t;

    // Clip windows in the shared sample ROM (end addresses inclusive)
    localparam logic [DEF_ADDR_W-1:0] WIN_START    = 18'h00000;
    localparam logic [DEF_ADDR_W-1:0] WIN_END      = 18'h0BB7F;
    localparam logic [DEF_ADDR_W-1:0] MOO_START    = 18'h0BB80;
    localparam logic [DEF_ADDR_W-1:0] MOO_END      = 18'h1D4BF;
    localparam logic [DEF_ADDR_W-1:0] DETECT_START = 18'h1D4C0;
    localparam logic [DEF_ADDR_W-1:0] DETECT_END   = 18'h2327F;
    localparam logic [DEF_ADDR_W-1:0] CHEER_START  = 18'h23280;
    localparam logic [DEF_ADDR_W-1:0] CHEER_END    = 18'h3A97F;

endpackage

// File: rtl/sample_rate_div.sv
// Sample-rate divider: counts 0..CLK_DIV-1 while enabled and flags the last count.
// Held at zero when disabled or cleared so every new period starts aligned.
module sample_rate_div #(
    parameter int CLK_DIV = 1200
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clip_sequencer.sv
// Multi-clip sample player: walks a ROM address window at the divided sample rate
// and hands each sample to the audio controller through a registered write strobe.
module clip_sequencer
    import audio_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int NUM_CLIPS  = 4,
    parameter int CLIP_W     = 2,
    parameter int CLK_DIV    = 1200,
    parameter int ROM_LAT    = 1,
    parameter int STEREO_DUP = 1
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [NUM_CLIPS*ADDR_W-1:0]   clip_start_flat,
    input  logic [NUM_CLIPS*ADDR_W-1:0]   clip_end_flat,
    input  logic                          trig,
    input  logic [CLIP_W-1:0]             clip_sel,
    input  logic                          loop_mode,
    input  logic                          stop,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [SAMPLE_W-1:0]           rom_q,
    input  logic                          audio_out_allowed,
    output logic                          write_audio_out,
    output logic [OUT_W-1:0]              left_channel_audio_out,
    output logic [OUT_W-1:0]              right_channel_audio_out,
    output logic                          busy,
    output logic [CLIP_W-1:0]             cur_clip,
    output logic                          done,
    output logic                          drop
);

    // rom_addr is held for a whole sample period, so the ROM must settle inside one
    if (CLK_DIV <= ROM_LAT) begin : g_bad_div
        $error("clip_sequencer: CLK_DIV must exceed ROM_LAT");
    end

    function automatic logic [OUT_W-1:0] justify(input logic [SAMPLE_W-1:0] s);
        return {s, {(OUT_W-SAMPLE_W){1'b0}}};
    endfunction

    play_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   start_r, end_r;
    logic                loop_r;
    logic [SAMPLE_W-1:0] sample_p0;
    logic                vld_p0;

    logic [ADDR_W-1:0]   sel_start, sel_end;
    logic                clip_ok, load, div_tick, tick_eff, at_end, last_tick, wr_fire;

    always_comb begin
        sel_start = '0;
        sel_end   = '0;
        clip_ok   = 1'b0;
        for (int k = 0; k < NUM_CLIPS; k++) begin
            if (clip_sel == CLIP_W'(k)) begin
                sel_start = clip_start_flat[k*ADDR_W +: ADDR_W];
                sel_end   = clip_end_flat[k*ADDR_W +: ADDR_W];
                clip_ok   = 1'b1;
            end
        end
    end

    sample_rate_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (CLOCK_50),
        .reset (reset),
        .clr   (load || stop),
        .en    (state_q == ST_PLAY),
        .tick  (div_tick)
    );

    // Next state and per-cycle control; stop outranks trig, trig outranks a tick
    always_comb begin
        state_d   = state_q;
        load      = trig && clip_ok && (sel_start <= sel_end) && !stop;
        tick_eff  = div_tick && !stop && !load;
        at_end    = (rom_addr == end_r);
        last_tick = tick_eff && at_end && !loop_r;
        wr_fire   = vld_p0 && audio_out_allowed && !tick_eff && !stop;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (load) begin
            state_d = ST_PLAY;
        end else if (last_tick) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            start_r         <= '0;
            end_r           <= '0;
            loop_r          <= 1'b0;
            rom_addr        <= '0;
            cur_clip        <= '0;
            sample_p0       <= '0;
            vld_p0          <= 1'b0;
            write_audio_out <= 1'b0;
            done            <= 1'b0;
            drop            <= 1'b0;
        end else begin
            state_q         <= state_d;
            write_audio_out <= wr_fire;
            done            <= last_tick;
            drop            <= tick_eff && vld_p0;
            if (load) begin
                start_r  <= sel_start;
                end_r    <= sel_end;
                loop_r   <= loop_mode;
                cur_clip <= clip_sel;
                rom_addr <= sel_start;
            end else if (tick_eff && !at_end) begin
                rom_addr <= rom_addr + 1'b1;
            end else if (tick_eff && loop_r) begin
                rom_addr <= start_r;
            end
            // Sample stage: latch at the tick, retire on write, go silent after the last write
            if (stop) begin
                sample_p0 <= '0;
                vld_p0    <= 1'b0;
            end else if (tick_eff) begin
                sample_p0 <= rom_q;
                vld_p0    <= 1'b1;
            end else if (wr_fire) begin
                vld_p0    <= 1'b0;
            end else if (write_audio_out && state_q == ST_IDLE) begin
                sample_p0 <= '0;
            end
        end
    end

    assign busy                    = (state_q == ST_PLAY);
    assign left_channel_audio_out  = justify(sample_p0);
    assign right_channel_audio_out = (STEREO_DUP != 0) ? justify(sample_p0) : '0;

endmodule
